// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge-magnitude stage: WIDTH x HEIGHT 8-bit frame in, (WIDTH-2) x (HEIGHT-2) out.
// Define SOBEL_THRESHOLD_EN to binarize the unsaturated magnitude against thr instead of saturating it.
module sobel_stream_filter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sop,
  input  logic       in_eop,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sop,
  output logic       out_eop,
  input  logic       out_ready,
  input  logic [7:0] thr,
  output logic       frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_cur;
  logic [RW-1:0] row, row_cur;
  logic          take, frame_end, emit;

  logic [7:0] line_old [WIDTH];
  logic [7:0] line_mid [WIDTH];
  logic [7:0] win [3][3];
  logic [7:0] col_top, col_mid;

  logic [10:0]        left_sum, right_sum, top_sum, bot_sum;
  logic signed [10:0] gx, gy;
  logic [10:0]        abs_gx, abs_gy, mag;
  logic [7:0]         pix_res;

  logic unused_in_eop;
  assign unused_in_eop = in_eop;

  // Weighted 1-2-1 sum of three pixels, zero-extended so it can never overflow 11 bits.
  function automatic logic [10:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return 11'(a) + (11'(b) << 1) + 11'(c);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = RUN;
      RUN:     if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In IDLE without sop the beat is accepted and dropped, independent of the output register.
  always_comb begin
    in_ready = 1'b1;
    if (state != IDLE || in_sop) in_ready = !out_valid || out_ready;
  end

  // An accepted sop always re-anchors the frame at (0,0), whatever the counters say.
  assign col_cur   = in_sop ? '0 : col;
  assign row_cur   = in_sop ? '0 : row;
  assign take      = in_valid && in_ready && (state == RUN || in_sop);
  assign frame_end = take && (row_cur == ROW_LAST) && (col_cur == COL_LAST);
  assign emit      = take && (row_cur >= RW'(2)) && (col_cur >= CW'(2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (take) begin
      if (frame_end) begin
        row <= '0;
        col <= '0;
      end else if (col_cur == COL_LAST) begin
        row <= row_cur + RW'(1);
        col <= '0;
      end else begin
        row <= row_cur;
        col <= col_cur + CW'(1);
      end
    end
  end

  assign col_top = line_old[col_cur];
  assign col_mid = line_mid[col_cur];

  // NOTE: line buffers and window are not reset; rows 0 and 1 of each frame overwrite them before any output reads them.
  always_ff @(posedge clk) begin
    if (take) begin
      line_old[col_cur] <= col_mid;
      line_mid[col_cur] <= in_data;
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= col_top;
      win[1][2] <= col_mid;
      win[2][2] <= in_data;
    end
  end

  // The kernel sees the window after this pixel shifts in: old columns 1,2 plus the incoming column.
  always_comb begin
    left_sum  = wsum(win[0][1], win[1][1], win[2][1]);
    right_sum = wsum(col_top, col_mid, in_data);
    top_sum   = wsum(win[0][1], win[0][2], col_top);
    bot_sum   = wsum(win[2][1], win[2][2], in_data);
    gx        = $signed(right_sum) - $signed(left_sum);
    gy        = $signed(bot_sum) - $signed(top_sum);
    abs_gx    = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy    = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    mag       = abs_gx + abs_gy;
  end

`ifdef SOBEL_THRESHOLD_EN
  assign pix_res = (mag >= {3'b000, thr}) ? 8'hFF : 8'h00;
`else
  logic unused_thr;
  assign unused_thr = ^thr;
  assign pix_res    = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_eop;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= pix_res;
        out_sop   <= (row_cur == RW'(2)) && (col_cur == CW'(2));
        out_eop   <= frame_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter (5x4 frames): scoreboard fed by a per-pixel Sobel model.
// Exercises the SOBEL_THRESHOLD_EN build when that macro is defined.
module tb_sobel_stream_filter;

  localparam int W = 5;
  localparam int H = 4;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sop;
  logic       in_eop;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic       out_ready;
  logic [7:0] thr;
  logic       frame_done;

  int    vectors     = 0;
  int    miscompares = 0;
  int    xfer_count  = 0;
  int    fd_count    = 0;
  bit    in_frame    = 0;
  bit    gap_en      = 0;
  int    ready_mode  = 0;
  int    rdy_phase   = 0;
  beat_t exp_q[$];
  logic [7:0] frame [H][W];

  bit    prev_hold     = 0;
  bit    prev_eop_xfer = 0;
  beat_t held, exp_b;
  logic  exp_rdy;

  sobel_stream_filter #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_ready  (out_ready),
    .thr        (thr),
    .frame_done (frame_done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // out_ready: 0 = always ready, 1 = repeating 1-0-0-1, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        1: begin
          out_ready = (rdy_phase == 0 || rdy_phase == 3);
          rdy_phase = (rdy_phase + 1) % 4;
        end
        2:       out_ready = 1'($urandom_range(1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Reference model: Sobel magnitude of every full 3x3 window in the current frame.
  function automatic void push_expected();
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        int    p [3][3];
        int    gx, gy, mag;
        beat_t b;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            p[i][j] = int'(frame[r-2+i][c-2+j]);
        gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
        b.data = (mag >= int'(thr)) ? 8'hFF : 8'h00;
`else
        b.data = (mag > 255) ? 8'hFF : 8'(mag);
`endif
        b.sop = (r == 2 && c == 2);
        b.eop = (r == H-1 && c == W-1);
        exp_q.push_back(b);
      end
    end
  endfunction

  // Monitor: samples 1 time unit after the falling edge, when inputs and outputs are settled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_hold     = 0;
        prev_eop_xfer = 0;
      end else begin
        vectors++;
        if (frame_done !== prev_eop_xfer) begin
          miscompares++;
          $display("FAIL frame_done: got %b, expected %b at %0t", frame_done, prev_eop_xfer, $time);
        end
        if (frame_done === 1'b1) fd_count++;

        exp_rdy = (!out_valid || out_ready) ? 1'b1 : !(in_frame || in_sop);
        vectors++;
        if (in_ready !== exp_rdy) begin
          miscompares++;
          $display("FAIL in_ready: got %b, expected %b at %0t", in_ready, exp_rdy, $time);
        end

        if (prev_hold) begin
          vectors++;
          if (out_valid !== 1'b1 || out_data !== held.data || out_sop !== held.sop || out_eop !== held.eop) begin
            miscompares++;
            $display("FAIL hold: got v=%b d=%h sop=%b eop=%b, expected v=1 d=%h sop=%b eop=%b at %0t",
                     out_valid, out_data, out_sop, out_eop, held.data, held.sop, held.eop, $time);
          end
        end

        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          xfer_count++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL beat: got unexpected d=%h sop=%b eop=%b, expected no beat at %0t",
                     out_data, out_sop, out_eop, $time);
          end else begin
            exp_b = exp_q.pop_front();
            if (out_data !== exp_b.data || out_sop !== exp_b.sop || out_eop !== exp_b.eop) begin
              miscompares++;
              $display("FAIL beat: got d=%h sop=%b eop=%b, expected d=%h sop=%b eop=%b at %0t",
                       out_data, out_sop, out_eop, exp_b.data, exp_b.sop, exp_b.eop, $time);
            end
          end
        end

        prev_hold     = out_valid && !out_ready;
        held          = '{out_data, out_sop, out_eop};
        prev_eop_xfer = out_valid && out_ready && out_eop;
      end
    end
  end

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic sop, input logic eop);
    bit acc    = 0;
    int waited = 0;
    if (gap_en && $urandom_range(2) == 0) idle_inputs();
    while (!acc) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = sop;
      in_eop   = eop;
      #1 acc = in_ready;
      @(posedge clk);
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          vectors++;
          miscompares++;
          $display("FAIL accept_timeout: pixel %h not accepted after %0d cycles, expected acceptance", d, waited);
          return;
        end
      end
    end
    if (sop) in_frame = 1;
    if (eop) in_frame = 0;
  endtask

  task automatic send_frame();
    push_expected();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pixel(frame[r][c], (r == 0 && c == 0), (r == H-1 && c == W-1));
    idle_inputs();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: got %0d beats outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_counts(input string name, input int dx, input int dfd, input int exp_x, input int exp_fd);
    vectors++;
    if (dx != exp_x) begin
      miscompares++;
      $display("FAIL %s beats: got %0d, expected %0d", name, dx, exp_x);
    end
    vectors++;
    if (dfd != exp_fd) begin
      miscompares++;
      $display("FAIL %s frame_done pulses: got %0d, expected %0d", name, dfd, exp_fd);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = v;
  endtask

  task automatic fill_step();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = (c < 2) ? 8'd0 : 8'd100;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = ($urandom_range(3) == 0) ? 8'($urandom_range(1) * 255) : 8'($urandom);
  endtask

  task automatic run_frame(input string name);
    int x0  = xfer_count;
    int fd0 = fd_count;
    send_frame();
    wait_drain(name);
    check_counts(name, xfer_count - x0, fd_count - fd0, (W-2)*(H-2), 1);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;
    thr      = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({out_valid, out_sop, out_eop, frame_done, out_data} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b sop=%b eop=%b fd=%b d=%h, expected all 0",
               out_valid, out_sop, out_eop, frame_done, out_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_constant();
    ready_mode = 0;
    gap_en     = 0;
    thr        = 8'($urandom);
    fill_const(8'h40);
    run_frame("constant");
  endtask

  task automatic test_step_edge();
    ready_mode = 0;
    gap_en     = 0;
    fill_step();
    run_frame("step_edge");
  endtask

  task automatic test_backpressure();
    ready_mode = 1;
    rdy_phase  = 0;
    gap_en     = 0;
    fill_step();
    run_frame("backpressure");
    ready_mode = 0;
  endtask

  task automatic test_drop_before_sop();
    int x0;
    ready_mode = 0;
    gap_en     = 0;
    x0 = xfer_count;
    for (int i = 0; i < 7; i++) send_pixel(8'($urandom), 1'b0, 1'b0);
    fill_random();
    for (int i = 0; i < W + 2; i++) send_pixel(frame[i / W][i % W], (i == 0), 1'b0);
    idle_inputs();
    repeat (3) @(negedge clk);
    vectors++;
    if (xfer_count != x0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_before_sop: got %0d beats, out_valid=%b, expected 0 beats", xfer_count - x0, out_valid);
    end
    fill_random();
    run_frame("restart");
  endtask

  task automatic test_threshold();
`ifdef SOBEL_THRESHOLD_EN
    ready_mode = 0;
    gap_en     = 0;
    thr = 8'd200;
    fill_step();
    run_frame("threshold_step");
    thr = 8'h00;
    fill_const(8'h40);
    run_frame("threshold_zero");
`endif
  endtask

  task automatic test_back_to_back();
    int x0, fd0;
    ready_mode = 2;
    gap_en     = 1;
    for (int k = 0; k < 4; k++) begin
      thr = 8'($urandom);
      x0  = xfer_count;
      fd0 = fd_count;
      for (int f = 0; f < 3; f++) begin
        fill_random();
        push_expected();
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            send_pixel(frame[r][c], (r == 0 && c == 0), (r == H-1 && c == W-1));
      end
      idle_inputs();
      wait_drain("back_to_back");
      check_counts("back_to_back", xfer_count - x0, fd_count - fd0, 3*(W-2)*(H-2), 3);
    end
    ready_mode = 0;
    gap_en     = 0;
  endtask

  task automatic test_reset_mid_frame();
    int x0, fd0;
    ready_mode = 0;
    gap_en     = 0;
    fill_random();
    push_expected();
    x0 = xfer_count;
    for (int i = 0; i < 2*W + 5; i++) send_pixel(frame[i / W][i % W], (i == 0), 1'b0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || xfer_count - x0 != 2) begin
      miscompares++;
      $display("FAIL pre_reset: got out_valid=%b beats=%0d, expected 1 and 2", out_valid, xfer_count - x0);
    end
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: got out_valid=%b, expected 0", out_valid);
    end
    exp_q.delete();
    in_frame = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      vectors++;
      if (frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_frame_done: got %b, expected 0", frame_done);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    fd0 = fd_count;
    fill_random();
    run_frame("after_reset");
    vectors++;
    if (fd_count - fd0 != 1) begin
      miscompares++;
      $display("FAIL reset_total_done: got %0d pulses, expected 1", fd_count - fd0);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_step_edge();
    test_backpressure();
    test_drop_before_sop();
    test_threshold();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_stream_filter.md
Name: sobel_stream_filter

Overview:
- Streaming 3x3 Sobel edge-magnitude stage in the edge-detection accelerator datapath.
- Sits between the SDRAM pixel reader (upstream, 8-bit grayscale Avalon-ST) and the frame-buffer writer that feeds the clocked-video output (downstream).
- Consumes one WIDTH x HEIGHT frame and produces a (WIDTH-2) x (HEIGHT-2) magnitude frame, plus a done pulse for the HPS start/done handshake.

Parameters:
- WIDTH, 640, input pixels per line; legal range 3..4096.
- HEIGHT, 480, input lines per frame; legal range 3..4096.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  grayscale pixel.
- in_valid  in  1  upstream pixel valid.
- in_sop  in  1  first pixel of frame; qualified by in_valid.
- in_eop  in  1  last pixel of frame; informational, not required for framing.
- in_ready  out  1  stage can accept a pixel this cycle.
- out_data  out  8  edge magnitude.
- out_valid  out  1  out_data valid.
- out_sop  out  1  first output pixel of frame.
- out_eop  out  1  last output pixel of frame.
- out_ready  in  1  downstream accepts.
- thr  in  8  binarization threshold; used only with the optional feature.
- frame_done  out  1  one-cycle pulse when the out_eop beat is accepted.

Behaviour:
- Reset: out_valid, out_sop, out_eop, frame_done, and out_data all 0. Row/col counters 0. State IDLE. Line buffers are not cleared.
- Transfer rule: a beat transfers when valid && ready on the same edge.
- Ready: in_ready = (state != IDLE || in_sop) ? (!out_valid || out_ready) : 1.
  - One output register only, so at most one result is in flight.
- States:
  - IDLE: drops pixels until an accepted beat with in_sop=1. That beat is pixel (0,0); go to RUN.
  - RUN: each accepted pixel advances col; col wraps WIDTH-1 -> 0 and increments row.
    - After pixel (HEIGHT-1, WIDTH-1) is accepted, go to IDLE.
    - An accepted in_sop in RUN restarts the frame: that pixel becomes (0,0).
    - The in-flight output beat is still delivered.
- Window:
  - Two WIDTH x 8 line buffers hold rows r-1 and r-2.
  - A 3x3 register window shifts on every accepted pixel.
  - Line buffers are written at col on accept.
- Output generation: on accepting pixel (r,c) with r>=2 and c>=2, compute for the window centred at (r-1,c-1):
  - Gx = (p[0][2] + 2p[1][2] + p[2][2]) - (p[0][0] + 2p[1][0] + p[2][0]), 11-bit signed.
  - Gy = (p[2][0] + 2p[2][1] + p[2][2]) - (p[0][0] + 2p[0][1] + p[0][2]), 11-bit signed.
  - mag = |Gx| + |Gy|, 11-bit unsigned, max 2040. out_data = min(mag, 255).
  - Row index: p[0] = oldest line (r-2). Column index: [0] = column c-2.
- Output timing: registered; out_valid rises the cycle after the qualifying accept. Latency is 1 cycle.
- Output framing:
  - out_sop = 1 on the result for (r=2, c=2).
  - out_eop = 1 on the result for (HEIGHT-1, WIDTH-1).
- Output hold: out_data, out_sop, out_eop, and out_valid stay stable while out_valid && !out_ready.
- Pixels with r<2 or c<2 produce no output beat but are accepted and stored.
- frame_done: pulses 1 cycle after out_eop transfers.
- Reset mid-frame: all control state returns to reset values immediately; the partial frame is discarded.

Optional Feature:
- Macro SOBEL_THRESHOLD_EN.
  - Defined: out_data = (mag >= thr) ? 8'hFF : 8'h00, comparing the unsaturated 11-bit mag against zero-extended thr.
  - Undefined: thr is ignored and out_data is the saturated magnitude.
- Port list is identical in both builds.

Test Plan:
- WIDTH=5, HEIGHT=4, all pixels 0x40, out_ready=1 -> 6 beats, all 0x00.
  - sop on beat 1, eop on beat 6.
  - frame_done pulses once, 1 cycle after beat 6.
- WIDTH=5, HEIGHT=4, columns 0-1 = 0, columns 2-4 = 100 -> rows of 255, 255, 0; 6 beats total.
- Same stimulus as the previous scenario, with out_ready toggling 1-0-0-1 continuously:
  - Identical 6-beat sequence.
  - in_ready = 0 whenever out_valid && !out_ready.
  - No beat lost or duplicated.
- Pixels sent before any sop -> no output, in_ready stays 1.
  - Then sop at row 1 of a frame -> counters restart; a full 6-beat frame follows.
- SOBEL_THRESHOLD_EN defined, thr=200, step-edge frame -> 0xFF, 0xFF, 0x00 per row.
  - With thr=0x00 and the constant frame -> all 0xFF.
- reset_n asserted after the 2nd output beat:
  - out_valid drops immediately; frame_done stays 0.
  - A fresh frame after release produces all 6 beats correctly.
